// File: rtl/uart_model_pkg.sv
// Types and helpers shared by the UART behavioural models (tx side and the
// future rx side).
package uart_model_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with occupancy count; DEPTH must be a power of two so
// the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // push and pop together leave the occupancy unchanged
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_model.sv
// Queued UART transmitter: byte FIFO feeding a start/data/stop frame
// serialiser with a registered line output.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line high; pops the FIFO head when tx_en=1 and data queued
//   ST_START | start bit (line low) for one bit period
//   ST_DATA  | PAYLOAD_BITS data bits, LSB first, one bit period each
//   ST_STOP  | line high for STOP_BITS bit periods, then back to idle
module uart_tx_model
  import uart_model_pkg::*;
#(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          tx_en,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CPB        = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int          CW         = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] BIT_RELOAD = CW'(CPB - 1);
  localparam logic [2:0]  LAST_DATA  = 3'(PAYLOAD_BITS - 1);
  localparam logic        LAST_STOP  = 1'(STOP_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic          txd_q, txd_d;
  logic          rdy_q, rdy_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;

  assign tx_ready  = rdy_q & ~fifo_full;
  assign fifo_push = tx_valid & tx_ready;
  assign uart_txd  = txd_q;
  assign tx_busy   = (state_q != ST_IDLE) | (fifo_count != '0);
  assign rdy_d     = 1'b1;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (fifo_push),
    .wr_data (tx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    fifo_pop = 1'b0;

    // cnt_q counts down the remaining cycles of the current bit
    case (state_q)
      ST_IDLE: begin
        if (tx_en && !fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          cnt_d    = BIT_RELOAD;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          cnt_d   = BIT_RELOAD;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_RELOAD;
          if (bit_q == LAST_DATA) begin
            stop_d  = 1'b0;
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (stop_q == LAST_STOP) begin
            state_d = ST_IDLE;
          end else begin
            stop_d = 1'b1;
            cnt_d  = BIT_RELOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // line value follows the next state so the registered output lines up
    // with state_q
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      txd_q   <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_model.sv
// Scoreboard bench for uart_tx_model: queued bytes are expected as whole
// frames on uart_txd, decoded by an independent line monitor.
module tb_uart_tx_model;

  localparam int CPB   = 10;
  localparam int NB    = 8;
  localparam int FRAME = CPB * (1 + NB + 1);

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tx_en = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, uart_txd, tx_busy;
  logic [4:0] fifo_count;

  logic       tx_en7 = 1'b1;
  logic       tx_valid7 = 1'b0;
  logic [7:0] tx_data7 = 8'h00;
  logic       tx_ready7, uart_txd7, tx_busy7;
  logic [2:0] fifo_count7;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_seen = 0;
  bit mon_busy = 1'b0;
  byte unsigned exp_q[$];
  int starts[$];
  string rx_line = "";
  string last_line = "";

  uart_tx_model #(
    .BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8),
    .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .resetn(resetn), .tx_en(tx_en), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .uart_txd(uart_txd),
    .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  uart_tx_model #(
    .BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(7),
    .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut7 (
    .clk(clk), .resetn(resetn), .tx_en(tx_en7), .tx_data(tx_data7),
    .tx_valid(tx_valid7), .tx_ready(tx_ready7), .uart_txd(uart_txd7),
    .tx_busy(tx_busy7), .fifo_count(fifo_count7)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: receive whole frames from the line and score them
  initial begin : monitor
    logic prev;
    logic smp [FRAME];
    bit aborted;
    byte unsigned exp_b, got_b;
    int bad, k;
    logic ebit;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        prev = 1'b1;
      end else if (prev === 1'b1 && uart_txd === 1'b0) begin
        mon_busy = 1'b1;
        frames_seen++;
        starts.push_back(cyc);
        smp[0] = uart_txd;
        aborted = 1'b0;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (resetn !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          smp[i] = uart_txd;
        end
        if (aborted) begin
          prev = 1'b1;
        end else begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: frame seen at cycle %0d, expected none", cyc);
          end else begin
            exp_b = exp_q.pop_front();
            bad = 0;
            for (int i = 0; i < FRAME; i++) begin
              k = i / CPB;
              ebit = (k == 0) ? 1'b0 : (k <= NB) ? exp_b[k-1] : 1'b1;
              if (smp[i] !== ebit) bad++;
            end
            got_b = 8'h00;
            for (int j = 0; j < NB; j++) got_b[j] = smp[CPB * (1 + j) + CPB / 2];
            if (bad != 0) begin
              errors++;
              $display("FAIL frame_wave: %0d bad cycles for byte %0h", bad, exp_b);
            end
            check("frame_byte", {24'h0, got_b}, {24'h0, exp_b});
            if (got_b == 8'h0A) begin
              last_line = rx_line;
              $display("TB_UART: %s", rx_line);
              rx_line = "";
            end else if (got_b >= 8'h20) begin
              rx_line = $sformatf("%s%c", rx_line, got_b);
            end
          end
          prev = smp[FRAME-1];
        end
        mon_busy = 1'b0;
      end else begin
        prev = uart_txd;
      end
    end
  end

  task automatic push_byte(input byte unsigned b, input bit accept);
    @(negedge clk);
    check("tx_ready", {31'h0, tx_ready}, {31'h0, accept});
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    if (accept) exp_q.push_back(b);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((tx_busy !== 1'b0 || mon_busy) && n < max_cyc);
    @(negedge clk);
    check({name, "_idle"}, {31'h0, (n < max_cyc)}, 32'h1);
  endtask

  task automatic wait_start(input string name);
    int n;
    logic p;
    n = 0;
    p = 1'b1;
    @(negedge clk);
    while (!(p === 1'b1 && uart_txd === 1'b0) && n < 400) begin
      p = uart_txd;
      @(negedge clk);
      n++;
    end
    check({name, "_start"}, {31'h0, (n < 400)}, 32'h1);
  endtask

  task automatic frame7(input byte unsigned b, input string name);
    logic s [110];
    int busy_end, bad, n, k;
    logic p, ebit;
    byte unsigned got;
    @(negedge clk);
    tx_data7  = b;
    tx_valid7 = 1'b1;
    @(posedge clk);
    #1 tx_valid7 = 1'b0;
    n = 0;
    p = 1'b1;
    @(negedge clk);
    while (!(p === 1'b1 && uart_txd7 === 1'b0) && n < 50) begin
      p = uart_txd7;
      @(negedge clk);
      n++;
    end
    check({name, "_start"}, {31'h0, (n < 50)}, 32'h1);
    busy_end = -1;
    for (int i = 0; i < 110; i++) begin
      if (i > 0) @(negedge clk);
      s[i] = uart_txd7;
      if (busy_end < 0 && tx_busy7 === 1'b0) busy_end = i;
    end
    bad = 0;
    for (int i = 0; i < 110; i++) begin
      k = i / CPB;
      ebit = (k == 0) ? 1'b0 : (k <= 7) ? b[k-1] : 1'b1;
      if (s[i] !== ebit) bad++;
    end
    got = 8'h00;
    for (int j = 0; j < 7; j++) got[j] = s[CPB * (1 + j) + CPB / 2];
    check({name, "_wave_bad"}, bad, 0);
    check({name, "_frame_len"}, busy_end, 100);
    check({name, "_data"}, {24'h0, got}, {24'h0, b & 8'h7F});
  endtask

  initial begin : stimulus
    int s0, lows, seen, n;
    byte unsigned fill [17];

    // reset
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, tx_ready}, 32'h0);
    check("rst_txd", {31'h0, uart_txd}, 32'h1);
    check("rst_busy", {31'h0, tx_busy}, 32'h0);
    check("rst_count", {27'h0, fifo_count}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'h0, tx_ready}, 32'h1);
    tx_en = 1'b1;

    // single byte with latency check
    @(negedge clk);
    tx_data  = 8'h41;
    tx_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(8'h41);
    #1 tx_valid = 1'b0;
    @(negedge clk);
    check("latency_c1_txd", {31'h0, uart_txd}, 32'h1);
    @(negedge clk);
    check("latency_c2_txd", {31'h0, uart_txd}, 32'h0);
    wait_idle(300, "byte41");

    // back-to-back frames
    rx_line = "";
    push_byte(8'h48, 1'b1);
    push_byte(8'h69, 1'b1);
    push_byte(8'h0A, 1'b1);
    wait_idle(500, "hi");
    n = starts.size();
    check("b2b_gap1", starts[n-2] - starts[n-3], FRAME + 1);
    check("b2b_gap2", starts[n-1] - starts[n-2], FRAME + 1);
    check("hi_log", {31'h0, (last_line == "Hi")}, 32'h1);

    // fill the queue while disabled; 17th byte must be dropped
    tx_en = 1'b0;
    for (int i = 0; i < 17; i++) fill[i] = 8'($urandom);
    for (int i = 0; i < 17; i++) push_byte(fill[i], i < 16);
    @(negedge clk);
    check("full_count", {27'h0, fifo_count}, 32'd16);
    check("full_busy", {31'h0, tx_busy}, 32'h1);
    check("full_txd_idle", {31'h0, uart_txd}, 32'h1);
    tx_en = 1'b1;
    wait_idle(16 * (FRAME + 1) + 100, "drain16");

    // tx_en dropped mid data bit 3
    tx_en = 1'b0;
    push_byte(8'h55, 1'b1);
    push_byte(8'($urandom), 1'b1);
    push_byte(8'($urandom), 1'b1);
    tx_en = 1'b1;
    wait_start("en_mid");
    repeat (45) @(negedge clk);
    tx_en = 1'b0;
    repeat (55) @(negedge clk);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("en_off_line_high", lows, 0);
    check("en_off_count", {27'h0, fifo_count}, 32'd2);
    check("en_off_busy", {31'h0, tx_busy}, 32'h1);
    tx_en = 1'b1;
    wait_idle(500, "en_resume");

    // randomized traffic
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 150)) @(negedge clk);
      push_byte(8'($urandom), 1'b1);
    end
    wait_idle(3000, "random");

    // reset during data bit 4
    tx_en = 1'b0;
    push_byte(8'hA5, 1'b1);
    push_byte(8'h3C, 1'b1);
    tx_en = 1'b1;
    wait_start("rst_mid");
    repeat (55) @(negedge clk);
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_txd", {31'h0, uart_txd}, 32'h1);
    check("rst_mid_count", {27'h0, fifo_count}, 32'h0);
    check("rst_mid_busy", {31'h0, tx_busy}, 32'h0);
    resetn = 1'b1;
    seen = frames_seen;
    repeat (300) @(negedge clk);
    check("rst_no_frames", frames_seen - seen, 0);
    check("rst_idle_busy", {31'h0, tx_busy}, 32'h0);

    // 7 data bits, 2 stop bits
    frame7(8'hFF, "f7_ff");
    frame7(8'h95, "f7_95");

    s0 = exp_q.size();
    check("scoreboard_empty", s0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
